// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU controller and mem_responder.
// With MEM_PARITY_EN defined the bundle also carries par_inj / par_err.
interface mem_responder_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8
);
  logic                     req;
  logic                     rd;
  logic                     wr;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     ack;
  logic                     err;
  logic                     busy;
`ifdef MEM_PARITY_EN
  logic                     par_inj;
  logic                     par_err;

  modport master (
    output req, rd, wr, addr, wdata, par_inj,
    input  rdata, ack, err, busy, par_err
  );
  modport slave (
    input  req, rd, wr, addr, wdata, par_inj,
    output rdata, ack, err, busy, par_err
  );
`else
  modport master (
    output req, rd, wr, addr, wdata,
    input  rdata, ack, err, busy
  );
  modport slave (
    input  req, rd, wr, addr, wdata,
    output rdata, ack, err, busy
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Stallable memory model: req/ack handshake, WAIT_CYCLES wait states, DEPTH x DATA_WIDTH array.
// Optional MEM_PARITY_EN adds a per-word even-parity bit with error injection and checking.
module mem_responder #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int         DEPTH    = 2 ** ADDRESS_WIDTH;
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic even_par(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                   r_state;
  state_t                   w_next_state;
  logic [3:0]               r_cnt;
  logic [3:0]               w_next_cnt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_op_wr;
  logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_busy;

  logic                     w_accept;
  logic                     w_legal_acc;
  logic                     w_illegal_acc;
  logic                     w_commit;
  logic                     w_c_wr;
  logic [ADDRESS_WIDTH-1:0] w_c_addr;
  logic [DATA_WIDTH-1:0]    w_c_data;

  assign w_accept      = (r_state == ST_IDLE) && bus.req;
  assign w_legal_acc   = w_accept && (bus.rd ^ bus.wr);
  assign w_illegal_acc = w_accept && !(bus.rd ^ bus.wr);

  // With no wait states the commit happens on the accept edge, so it must use the live inputs.
  assign w_commit = (w_legal_acc && NO_WAIT) || ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_c_wr   = (r_state == ST_IDLE) ? bus.wr    : r_op_wr;
  assign w_c_addr = (r_state == ST_IDLE) ? bus.addr  : r_addr;
  assign w_c_data = (r_state == ST_IDLE) ? bus.wdata : r_wdata;

  // Next-state and wait-counter logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_legal_acc) begin
          if (NO_WAIT) begin
            w_next_state = ST_RESP;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = CNT_INIT;
          end
        end else if (w_illegal_acc) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State register, counter and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_legal_acc) begin
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_op_wr <= bus.wr;
      end
    end
  end

  // Memory array and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else if (w_commit) begin
      if (w_c_wr) r_mem[w_c_addr] <= w_c_data;
      else        r_rdata         <= r_mem[w_c_addr];
    end
  end

  // Handshake outputs track the state the FSM is about to enter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack  <= (w_next_state == ST_RESP);
      r_err  <= w_illegal_acc;
      r_busy <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

`ifdef MEM_PARITY_EN
  logic r_par_inj;
  logic r_par [DEPTH];
  logic r_par_err;
  logic w_c_inj;

  assign w_c_inj = (r_state == ST_IDLE) ? bus.par_inj : r_par_inj;

  // Parity storage; injection inverts the stored bit so the next read flags it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_inj <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_legal_acc) r_par_inj <= bus.par_inj;
      if (w_commit && w_c_wr) r_par[w_c_addr] <= even_par(w_c_data) ^ w_c_inj;
      r_par_err <= w_commit && !w_c_wr &&
                   (r_par[w_c_addr] != even_par(r_mem[w_c_addr]));
    end
  end

  assign bus.par_err = r_par_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES of 0, 2 and 3.
module tb_mem_responder;

  logic       clk;
  logic       rst;
  logic       req0, req2, req3;
  logic       rd_s, wr_s, par_inj_s;
  logic [4:0] addr_s;
  logic [7:0] wdata_s;
  int         sel;
  int         n_vec;
  int         n_err;

  logic       o_ack, o_err, o_busy, o_par;
  logic [7:0] o_rdata;

  mem_responder_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8)) if0 ();
  mem_responder_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8)) if2 ();
  mem_responder_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8)) if3 ();

  assign if0.req = req0;  assign if0.rd = rd_s;  assign if0.wr = wr_s;
  assign if0.addr = addr_s;  assign if0.wdata = wdata_s;
  assign if2.req = req2;  assign if2.rd = rd_s;  assign if2.wr = wr_s;
  assign if2.addr = addr_s;  assign if2.wdata = wdata_s;
  assign if3.req = req3;  assign if3.rd = rd_s;  assign if3.wr = wr_s;
  assign if3.addr = addr_s;  assign if3.wdata = wdata_s;
`ifdef MEM_PARITY_EN
  assign if0.par_inj = par_inj_s;
  assign if2.par_inj = par_inj_s;
  assign if3.par_inj = par_inj_s;
`endif

  mem_responder #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mem_responder #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  mem_responder #(.ADDRESS_WIDTH(5), .DATA_WIDTH(8), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  always_comb begin
    case (sel)
      0:       begin o_ack = if0.ack; o_err = if0.err; o_busy = if0.busy; o_rdata = if0.rdata; end
      3:       begin o_ack = if3.ack; o_err = if3.err; o_busy = if3.busy; o_rdata = if3.rdata; end
      default: begin o_ack = if2.ack; o_err = if2.err; o_busy = if2.busy; o_rdata = if2.rdata; end
    endcase
`ifdef MEM_PARITY_EN
    case (sel)
      0:       o_par = if0.par_err;
      3:       o_par = if3.par_err;
      default: o_par = if2.par_err;
    endcase
`else
    o_par = 1'b0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic v);
    case (which)
      0:       req0 = v;
      3:       req3 = v;
      default: req2 = v;
    endcase
  endtask

  // One request; inputs are scrambled after acceptance to prove they were latched.
  task automatic run_op(input int which, input logic r, input logic w, input logic [4:0] a,
                        input logic [7:0] d, input logic inj, input int exp_lat,
                        input logic exp_err, input logic [7:0] exp_rd, input string tag,
                        output logic par_at_ack);
    int n;
    sel = which;
    @(negedge clk);
    rd_s = r; wr_s = w; addr_s = a; wdata_s = d; par_inj_s = inj;
    set_req(which, 1'b1);
    @(posedge clk); #1;
    set_req(which, 1'b0);
    rd_s = w; wr_s = r; addr_s = ~a; wdata_s = ~d; par_inj_s = ~inj;
    chk({tag, ".busy_e0"}, {31'd0, o_busy}, 32'd1);
    n = 0;
    while (o_ack !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    par_at_ack = o_par;
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".err"}, {31'd0, o_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, {24'd0, o_rdata}, {24'd0, exp_rd});
    @(posedge clk); #1;
    chk({tag, ".ack_drop"}, {31'd0, o_ack}, 32'd0);
    chk({tag, ".idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  logic       p;
  logic       op_wr [4];
  logic [7:0] op_d  [4];
  logic [7:0] op_rd [4];
  int         acks;

  initial begin
    n_vec = 0; n_err = 0; sel = 2;
    rst = 1'b1; req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    rd_s = 1'b0; wr_s = 1'b0; par_inj_s = 1'b0; addr_s = 5'd0; wdata_s = 8'd0;
    #2;
    chk("rst.ack", {31'd0, o_ack}, 32'd0);
    chk("rst.busy", {31'd0, o_busy}, 32'd0);
    chk("rst.rdata", {24'd0, o_rdata}, 32'd0);
    #20 rst = 1'b0;

    // Populate, then reset mid-cycle while a write is in flight
    run_op(2, 1'b0, 1'b1, 5'd5, 8'h5A, 1'b0, 2, 1'b0, 8'h00, "wr5", p);
    run_op(2, 1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 2, 1'b0, 8'h5A, "rd5", p);
    @(negedge clk);
    rd_s = 1'b0; wr_s = 1'b1; addr_s = 5'd6; wdata_s = 8'h66; req2 = 1'b1;
    @(posedge clk); #1 req2 = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("midrst.rdata", {24'd0, o_rdata}, 32'd0);
    chk("midrst.ack", {31'd0, o_ack}, 32'd0);
    chk("midrst.err", {31'd0, o_err}, 32'd0);
    chk("midrst.busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(2, 1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 2, 1'b0, 8'h00, "rd5_after_rst", p);
    run_op(2, 1'b1, 1'b0, 5'd6, 8'h00, 1'b0, 2, 1'b0, 8'h00, "rd6_aborted", p);

    // W=2 write then read
    run_op(2, 1'b0, 1'b1, 5'd3, 8'hA5, 1'b0, 2, 1'b0, 8'h00, "wr3", p);
    run_op(2, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 2, 1'b0, 8'hA5, "rd3", p);

    // Illegal requests leave memory and rdata untouched
    run_op(2, 1'b0, 1'b1, 5'd7, 8'h11, 1'b0, 2, 1'b0, 8'hA5, "wr7", p);
    run_op(2, 1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 2, 1'b0, 8'h11, "rd7", p);
    run_op(2, 1'b1, 1'b1, 5'd7, 8'hFF, 1'b0, 0, 1'b1, 8'h11, "ill_both", p);
    run_op(2, 1'b0, 1'b1, 5'd2, 8'h22, 1'b0, 2, 1'b0, 8'h11, "wr2", p);
    run_op(2, 1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 2, 1'b0, 8'h11, "rd7_after_ill", p);
    run_op(2, 1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 2, 1'b0, 8'h22, "rd2", p);

    // W=0, req held high; RESP-cycle garbage write must be ignored
    sel = 0;
    op_wr = '{1'b1, 1'b0, 1'b1, 1'b0};
    op_d  = '{8'h44, 8'h00, 8'h45, 8'h00};
    op_rd = '{8'h00, 8'h44, 8'h44, 8'h45};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_s = !op_wr[i]; wr_s = op_wr[i]; addr_s = 5'd4; wdata_s = op_d[i]; req0 = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.ack", i), {31'd0, o_ack}, 32'd1);
      chk($sformatf("b2b%0d.rdata", i), {24'd0, o_rdata}, {24'd0, op_rd[i]});
      @(negedge clk);
      rd_s = 1'b0; wr_s = 1'b1; wdata_s = 8'hEE;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.ack_drop", i), {31'd0, o_ack}, 32'd0);
      chk($sformatf("b2b%0d.busy", i), {31'd0, o_busy}, 32'd0);
    end
    req0 = 1'b0;
    run_op(0, 1'b1, 1'b0, 5'd4, 8'h00, 1'b0, 0, 1'b0, 8'h45, "w0_rd4", p);
    run_op(0, 1'b0, 1'b0, 5'd4, 8'h99, 1'b0, 0, 1'b1, 8'h45, "w0_ill_none", p);
    run_op(0, 1'b1, 1'b0, 5'd4, 8'h00, 1'b0, 0, 1'b0, 8'h45, "w0_rd4_again", p);

`ifdef MEM_PARITY_EN
    run_op(2, 1'b0, 1'b1, 5'd1, 8'h0F, 1'b1, 2, 1'b0, 8'h22, "par_wr_inj", p);
    run_op(2, 1'b1, 1'b0, 5'd1, 8'h00, 1'b0, 2, 1'b0, 8'h0F, "par_rd_bad", p);
    chk("par_rd_bad.par_err", {31'd0, p}, 32'd1);
    run_op(2, 1'b0, 1'b1, 5'd1, 8'h0F, 1'b0, 2, 1'b0, 8'h0F, "par_wr_ok", p);
    run_op(2, 1'b1, 1'b0, 5'd1, 8'h00, 1'b0, 2, 1'b0, 8'h0F, "par_rd_ok", p);
    chk("par_rd_ok.par_err", {31'd0, p}, 32'd0);
`endif

    // W=3 normal access, then abort a write during WAIT
    run_op(3, 1'b0, 1'b1, 5'd10, 8'h77, 1'b0, 3, 1'b0, 8'h00, "w3_wr10", p);
    run_op(3, 1'b1, 1'b0, 5'd10, 8'h00, 1'b0, 3, 1'b0, 8'h77, "w3_rd10", p);
    sel = 3;
    @(negedge clk);
    rd_s = 1'b0; wr_s = 1'b1; addr_s = 5'd9; wdata_s = 8'h3C; req3 = 1'b1;
    @(posedge clk); #1 req3 = 1'b0;
    @(posedge clk); #1;
    chk("abort.busy_e1", {31'd0, o_busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("abort.busy", {31'd0, o_busy}, 32'd0);
    chk("abort.ack", {31'd0, o_ack}, 32'd0);
    chk("abort.rdata", {24'd0, o_rdata}, 32'd0);
    @(negedge clk) rst = 1'b0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (o_ack === 1'b1) acks++;
    end
    chk("abort.no_ack", acks, 0);
    run_op(3, 1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 3, 1'b0, 8'h00, "abort_rd9", p);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
